// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep stimulus/capture harness:
// FSM state encoding, MISR polynomial and maximal-length LFSR tap masks.
package sweep_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

   localparam logic [15:0] MISR_POLY16 = 16'h1021;

   // Fibonacci tap masks (bit k set = stage k+1 feeds back) for shift-left registers.
   function automatic logic [31:0] lfsr_taps(input int width);
      case (width)
         4:       return 32'h0000_000C;
         8:       return 32'h0000_00B8;
         12:      return 32'h0000_0E08;
         16:      return 32'h0000_D008;
         default: return 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/misr_compactor.sv
// Serial-input signature register: folds one response bit per enabled clock
// into a Galois-style shift register with polynomial POLY.
module misr_compactor
   import sweep_pkg::*;
#(
   parameter int               SIG_W = 16,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY16)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [SIG_W-1:0] sig
);

   // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig <= '0;
      end else if (clr) begin
         sig <= '0;
      end else if (en) begin
         sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(din);
      end
   end

endmodule

// File: rtl/sweep_stim_capture.sv
// Drives every input vector of a combinational netlist (binary or LFSR order)
// and compacts its delayed response into a MISR signature and a ones count.
module sweep_stim_capture
   import sweep_pkg::*;
#(
   parameter int N_IN    = 12,
   parameter int CAP_LAT = 1,
   parameter int SIG_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              mode,
   input  logic [N_IN-1:0]   seed,
   output logic [N_IN-1:0]   vec_o,
   input  logic              dut_i,
   output logic              busy,
   output logic              done,
   output logic [SIG_W-1:0]  signature,
   output logic [N_IN:0]     ones_count
);

   localparam logic [N_IN-1:0] TAPS      = N_IN'(lfsr_taps(N_IN));
   localparam logic [N_IN-1:0] LAST_BIN  = '1;
   localparam logic [N_IN-1:0] LAST_LFSR = {{(N_IN-1){1'b1}}, 1'b0};
   localparam int              DW        = (CAP_LAT > 1) ? $clog2(CAP_LAT) : 1;

   state_t          state;
   logic            mode_r;
   logic [N_IN-1:0] vcnt;
   logic [DW-1:0]   dcnt;
   logic            start_go;
   logic            is_last;
   logic            issuing;
   logic            sample_en;
   logic            sample;

   assign start_go = start && !abort && (state == IDLE || state == DONE);
   assign is_last  = mode_r ? (vcnt == LAST_LFSR) : (vcnt == LAST_BIN);
   assign issuing  = (state == DRIVE);
   assign sample   = sample_en && !abort;

   // Valid tags follow each issued vector through the netlist latency.
   if (CAP_LAT == 0) begin : g_comb_path
      assign sample_en = issuing;
   end else begin : g_tag_pipe
      logic [CAP_LAT-1:0] tag;
      // NOTE: the tag pipeline is a control path, so it is reset; stale tags would cause phantom samples.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)     tag <= '0;
         else if (abort) tag <= '0;
         else            tag <= (tag << 1) | CAP_LAT'(issuing);
      end
      assign sample_en = tag[CAP_LAT-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mode_r <= 1'b0;
         vcnt   <= '0;
         dcnt   <= '0;
         vec_o  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (abort) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_go) begin
                  state  <= DRIVE;
                  busy   <= 1'b1;
                  done   <= 1'b0;
                  mode_r <= mode;
                  vcnt   <= '0;
                  vec_o  <= !mode ? '0 : (seed == '0) ? N_IN'(1) : seed;
               end
            end
            DRIVE: begin
               // Termination is detected on the last vector, so the counter never wraps onto vec_o.
               if (is_last) begin
                  dcnt <= '0;
                  if (CAP_LAT == 0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end else begin
                  vcnt  <= vcnt + N_IN'(1);
                  vec_o <= mode_r ? {vec_o[N_IN-2:0], ^(vec_o & TAPS)} : vec_o + N_IN'(1);
               end
            end
            DRAIN: begin
               if (dcnt == DW'(CAP_LAT - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  dcnt <= dcnt + DW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ones_count <= '0;
      else if (start_go) ones_count <= '0;
      else if (sample)   ones_count <= ones_count + {{N_IN{1'b0}}, dut_i};
   end

   misr_compactor #(
      .SIG_W (SIG_W),
      .POLY  (SIG_W'(MISR_POLY16))
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_go),
      .en    (sample),
      .din   (dut_i),
      .sig   (signature)
   );

endmodule

// File: tb/tb_sweep_stim_capture.sv
// Self-checking bench: table of full sweeps scored through a queue of expected
// results, plus hand-written abort, reset and start-collision sequences.
module tb_sweep_stim_capture;

   localparam int N_IN    = 12;
   localparam int CAP_LAT = 1;
   localparam int SIG_W   = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic              mode;
   logic [N_IN-1:0]   seed;
   logic [N_IN-1:0]   vec_o;
   logic              dut_i = 1'b0;
   logic              busy;
   logic              done;
   logic [SIG_W-1:0]  signature;
   logic [N_IN:0]     ones_count;

   typedef enum int {F_ZERO, F_ONE, F_BIT0, F_AND} fn_t;

   typedef struct {
      string           name;
      logic            mode;
      logic [N_IN-1:0] seed;
      fn_t             fn;
      int              poke_at;
      logic [N_IN-1:0] exp_first;
      int              exp_ones;
      int              exp_cycles;
      int              exp_distinct;
   } vec_t;

   typedef struct {
      logic [SIG_W-1:0] sig;
      int               ones;
      int               cycles;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[6];
   fn_t  fn = F_ZERO;
   bit   seen[4096];
   int   distinct;
   int   zero_seen;
   int   checks = 0;
   int   errors = 0;

   sweep_stim_capture #(.N_IN(N_IN), .CAP_LAT(CAP_LAT), .SIG_W(SIG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .mode       (mode),
      .seed       (seed),
      .vec_o      (vec_o),
      .dut_i      (dut_i),
      .busy       (busy),
      .done       (done),
      .signature  (signature),
      .ones_count (ones_count)
   );

   always #5 clk = ~clk;

   function automatic logic f_eval(input fn_t f, input logic [N_IN-1:0] v);
      case (f)
         F_ONE:   return 1'b1;
         F_BIT0:  return v[0];
         F_AND:   return &v;
         default: return 1'b0;
      endcase
   endfunction

   // Netlist with one register stage: response to vec_o appears one clock later.
   always @(posedge clk) dut_i <= f_eval(fn, vec_o);

   function automatic logic [SIG_W-1:0] ref_sig(input fn_t f, input int nvec);
      logic [SIG_W-1:0] s = '0;
      logic [N_IN-1:0]  v;
      for (int i = 0; i < nvec; i++) begin
         v = N_IN'(i);
         s = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? 16'h1021 : 16'h0000) ^ SIG_W'(f_eval(f, v));
      end
      return s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic mark();
      if (!seen[vec_o]) begin
         seen[vec_o] = 1'b1;
         distinct++;
      end
      if (vec_o == '0) zero_seen++;
   endtask

   task automatic run_sweep(input vec_t t);
      exp_t e;
      int   cycles;
      e.sig    = ref_sig(t.fn, t.mode ? 4095 : 4096);
      e.ones   = t.exp_ones;
      e.cycles = t.exp_cycles;
      sb.push_back(e);
      fn = t.fn;
      for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
      distinct  = 0;
      zero_seen = 0;
      @(negedge clk);
      start = 1'b1; mode = t.mode; seed = t.seed;
      @(negedge clk);
      start  = 1'b0;
      cycles = 0;
      check({t.name, "_first_vec"}, 32'(vec_o), 32'(t.exp_first));
      check({t.name, "_busy_on"}, 32'(busy), 32'd1);
      mark();
      while (!done && cycles < 10000) begin
         if (t.poke_at > 0 && cycles == t.poke_at) begin
            start = 1'b1;
            mode  = ~t.mode;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cycles++;
         if (busy) mark();
      end
      start = 1'b0;
      e = sb.pop_front();
      check({t.name, "_cycles"}, 32'(cycles), 32'(e.cycles));
      check({t.name, "_signature"}, 32'(signature), 32'(e.sig));
      check({t.name, "_ones"}, 32'(ones_count), 32'(e.ones));
      check({t.name, "_busy_off"}, 32'(busy), 32'd0);
      check({t.name, "_distinct"}, 32'(distinct), 32'(t.exp_distinct));
      if (t.mode) check({t.name, "_zero_seen"}, 32'(zero_seen), 32'd0);
   endtask

   initial begin
      tbl[0] = '{"zero_bin",   1'b0, 12'h000, F_ZERO, 0,  12'h000, 0,    4097, 4096};
      tbl[1] = '{"bit0_bin",   1'b0, 12'h3C3, F_BIT0, 0,  12'h000, 2048, 4097, 4096};
      tbl[2] = '{"and_bin",    1'b0, 12'h000, F_AND,  0,  12'h000, 1,    4097, 4096};
      tbl[3] = '{"one_lfsr0",  1'b1, 12'h000, F_ONE,  0,  12'h001, 4095, 4096, 4095};
      tbl[4] = '{"one_lfsrA",  1'b1, 12'hA5C, F_ONE,  0,  12'hA5C, 4095, 4096, 4095};
      tbl[5] = '{"poke_bin",   1'b0, 12'h000, F_ONE,  50, 12'h000, 4096, 4097, 4096};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; seed = '0;
      repeat (3) @(negedge clk);
      check("rst_vec", 32'(vec_o), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sig", 32'(signature), 32'd0);
      check("rst_ones", 32'(ones_count), 32'd0);
      rst_n = 1'b1;

      // start and abort together: abort wins, nothing starts.
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("start_abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("start_abort_busy2", 32'(busy), 32'd0);

      for (int i = 0; i < 6; i++) run_sweep(tbl[i]);

      // abort from DONE clears done and keeps results.
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_done_done", 32'(done), 32'd0);
      check("abort_done_ones", 32'(ones_count), 32'd4096);

      // abort on the 100th DRIVE edge: samples taken on edges 2..99 only.
      fn = F_ONE;
      @(negedge clk);
      start = 1'b1; mode = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_ones", 32'(ones_count), 32'd98);
      repeat (5) @(negedge clk);
      check("abort_ones_frozen", 32'(ones_count), 32'd98);
      check("abort_done_stays", 32'(done), 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_ones_clr", 32'(ones_count), 32'd0);
      check("restart_sig_clr", 32'(signature), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);

      // asynchronous reset in the middle of a sweep.
      repeat (200) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_vec", 32'(vec_o), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_sig", 32'(signature), 32'd0);
      check("midrst_ones", 32'(ones_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
